// File: rtl/symbol_framer.sv
// Packs a serial bitstream into 2/4/6/8-bit symbols with a valid/ready output
// and a symbol-rate clock phase-locked to the symbol boundaries.
module symbol_framer #(
    parameter int unsigned MAX_BPS   = 8,
    parameter int unsigned MODE_W    = 2,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned BPS_W    = $clog2(MAX_BPS + 1)
) (
    input  logic               clk_bitstream,
    input  logic               rst_n,
    input  logic [MODE_W-1:0]  mod_type,
    input  logic               flush,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic               bit_ready,
    output logic [MAX_BPS-1:0] sym_out,
    output logic [BPS_W-1:0]   sym_bps,
    output logic               sym_valid,
    input  logic               sym_ready,
    output logic               clk_symbol,
    output logic [BPS_W-1:0]   bit_idx
);

    localparam int unsigned REQ_W = (MODE_W + 2 > BPS_W) ? MODE_W + 2 : BPS_W;

    logic [BPS_W-1:0]   bit_cnt, bit_cnt_next;
    logic [MAX_BPS-1:0] shift, shift_next;
    logic [BPS_W-1:0]   active_bps, active_bps_next;
    logic               primed, primed_next;
    logic [MAX_BPS-1:0] sym_out_next;
    logic [BPS_W-1:0]   sym_bps_next;
    logic               sym_valid_next;
    logic               clk_symbol_next;

    logic [REQ_W-1:0]   req_full;
    logic [BPS_W-1:0]   req_bps;
    logic [BPS_W-1:0]   eff_bps;
    logic [BPS_W-1:0]   bit_pos;
    logic [MAX_BPS-1:0] word;
    logic               last_bit;
    logic               acc;

    // Mode is only sampled when a new symbol starts (bit_cnt == 0).
    always_comb begin
        req_full  = (REQ_W'(mod_type) + REQ_W'(1)) << 1;
        req_bps   = (req_full > REQ_W'(MAX_BPS)) ? BPS_W'(MAX_BPS) : BPS_W'(req_full);
        eff_bps   = (bit_cnt == '0) ? req_bps : active_bps;
        last_bit  = (bit_cnt == eff_bps - BPS_W'(1));
        bit_pos   = MSB_FIRST ? (eff_bps - BPS_W'(1) - bit_cnt) : bit_cnt;
        word      = shift | (MAX_BPS'(bit_in) << bit_pos);
        bit_ready = ~sym_valid | sym_ready | ~last_bit;
        acc       = bit_valid & bit_ready & ~flush;
    end

    // Next-state: flush outranks accept; a completion overrides the handshake clear.
    always_comb begin
        bit_cnt_next    = bit_cnt;
        shift_next      = shift;
        active_bps_next = active_bps;
        primed_next     = primed;
        sym_out_next    = sym_out;
        sym_bps_next    = sym_bps;
        sym_valid_next  = sym_valid & ~sym_ready;

        if (flush) begin
            bit_cnt_next = '0;
            shift_next   = '0;
        end else if (acc) begin
            if (bit_cnt == '0) begin
                active_bps_next = eff_bps;
            end
            if (last_bit) begin
                sym_out_next   = word;
                sym_bps_next   = eff_bps;
                sym_valid_next = 1'b1;
                bit_cnt_next   = '0;
                shift_next     = '0;
                primed_next    = 1'b1;
            end else begin
                shift_next   = word;
                bit_cnt_next = bit_cnt + BPS_W'(1);
            end
        end

        clk_symbol_next = primed_next & (bit_cnt_next < (active_bps_next >> 1));
    end

    always_ff @(posedge clk_bitstream or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            shift      <= '0;
            active_bps <= BPS_W'(2);
            primed     <= 1'b0;
            sym_out    <= '0;
            sym_bps    <= '0;
            sym_valid  <= 1'b0;
            clk_symbol <= 1'b0;
        end else begin
            bit_cnt    <= bit_cnt_next;
            shift      <= shift_next;
            active_bps <= active_bps_next;
            primed     <= primed_next;
            sym_out    <= sym_out_next;
            sym_bps    <= sym_bps_next;
            sym_valid  <= sym_valid_next;
            clk_symbol <= clk_symbol_next;
        end
    end

    assign bit_idx = bit_cnt;

endmodule

// File: tb/tb_symbol_framer.sv
// Randomised and directed bench for symbol_framer against a queue-based symbol model.
module tb_symbol_framer;

    logic       clk_bitstream = 1'b0;
    logic       rst_n;
    logic [1:0] mod_type;
    logic       flush, bit_in, bit_valid, sym_ready;

    logic       bit_ready, sym_valid, clk_symbol;
    logic [7:0] sym_out;
    logic [3:0] sym_bps, bit_idx;

    logic       bit_ready_b, sym_valid_b, clk_symbol_b;
    logic [3:0] sym_out_b;
    logic [2:0] sym_bps_b, bit_idx_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: bits of the partial symbol, its size, and the held output.
    bit   m_bits[$];
    int   m_bps;
    bit   m_held;
    bit   m_primed;
    logic [7:0] m_word;
    int   m_wbps;

    logic [7:0] obs_w[$];
    int         obs_bps[$];
    logic [3:0] obs_wb[$];
    int         obs_bpsb[$];
    int         acc_cnt;

    always #5 clk_bitstream = ~clk_bitstream;

    symbol_framer dut (
        .clk_bitstream(clk_bitstream), .rst_n(rst_n), .mod_type(mod_type),
        .flush(flush), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .sym_out(sym_out), .sym_bps(sym_bps), .sym_valid(sym_valid),
        .sym_ready(sym_ready), .clk_symbol(clk_symbol), .bit_idx(bit_idx)
    );

    symbol_framer #(.MAX_BPS(4), .MODE_W(2), .MSB_FIRST(1'b0)) dut_b (
        .clk_bitstream(clk_bitstream), .rst_n(rst_n), .mod_type(mod_type),
        .flush(flush), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready_b),
        .sym_out(sym_out_b), .sym_bps(sym_bps_b), .sym_valid(sym_valid_b),
        .sym_ready(1'b1), .clk_symbol(clk_symbol_b), .bit_idx(bit_idx_b)
    );

    task automatic model_reset();
        m_bits.delete();
        m_bps    = 2;
        m_held   = 1'b0;
        m_primed = 1'b0;
        m_word   = '0;
        m_wbps   = 0;
    endtask

    task automatic clear_obs();
        obs_w.delete(); obs_bps.delete(); obs_wb.delete(); obs_bpsb.delete();
        acc_cnt = 0;
    endtask

    // One bit-clock cycle: drive at negedge, check bit_ready, advance model, check registers.
    task automatic step(input bit v, input bit b, input int mode, input bit sr, input bit fl);
        int req, eff, sz;
        bit exp_rdy, exp_clk;
        mod_type  = 2'(mode);
        bit_valid = v;
        bit_in    = b;
        sym_ready = sr;
        flush     = fl;
        #1;
        req = 2 * (mode + 1);
        if (req > 8) req = 8;
        sz  = m_bits.size();
        eff = (sz == 0) ? req : m_bps;
        exp_rdy = !m_held || sr || (sz != eff - 1);
        n_tests++;
        if (bit_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL bit_ready @%0t: got %b expected %b", $time, bit_ready, exp_rdy);
        end
        if (sym_valid && sr) begin
            obs_w.push_back(sym_out);
            obs_bps.push_back(int'(sym_bps));
        end
        if (sym_valid_b) begin
            obs_wb.push_back(sym_out_b);
            obs_bpsb.push_back(int'(sym_bps_b));
        end
        if (v && bit_ready && !fl) acc_cnt++;

        if (m_held && sr) m_held = 1'b0;
        if (fl) begin
            m_bits.delete();
        end else if (v && exp_rdy) begin
            if (sz == 0) m_bps = eff;
            m_bits.push_back(b);
            if (m_bits.size() == m_bps) begin
                m_word = '0;
                for (int i = 0; i < m_bps; i++) m_word[m_bps - 1 - i] = m_bits[i];
                m_wbps   = m_bps;
                m_held   = 1'b1;
                m_primed = 1'b1;
                m_bits.delete();
            end
        end
        exp_clk = m_primed && (m_bits.size() < m_bps / 2);

        @(posedge clk_bitstream);
        @(negedge clk_bitstream);
        n_tests++;
        if (sym_valid !== m_held) begin
            n_fail++;
            $display("FAIL sym_valid @%0t: got %b expected %b", $time, sym_valid, m_held);
        end
        if (m_held) begin
            n_tests++;
            if (sym_out !== m_word || sym_bps !== 4'(m_wbps)) begin
                n_fail++;
                $display("FAIL sym_out @%0t: got %h/%0d expected %h/%0d",
                         $time, sym_out, sym_bps, m_word, m_wbps);
            end
        end
        n_tests++;
        if (clk_symbol !== exp_clk) begin
            n_fail++;
            $display("FAIL clk_symbol @%0t: got %b expected %b", $time, clk_symbol, exp_clk);
        end
        n_tests++;
        if (bit_idx !== 4'(m_bits.size())) begin
            n_fail++;
            $display("FAIL bit_idx @%0t: got %0d expected %0d", $time, bit_idx, m_bits.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mod_type = '0; flush = 0; bit_in = 0; bit_valid = 0; sym_ready = 0;
        model_reset();
        #12;
        n_tests++;
        if ({sym_out, sym_bps, sym_valid, clk_symbol, bit_idx} !== '0 || bit_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: got out=%h bps=%0d v=%b clk=%b idx=%0d rdy=%b expected zeros, rdy=1",
                     sym_out, sym_bps, sym_valid, clk_symbol, bit_idx, bit_ready);
        end
        @(negedge clk_bitstream);
        rst_n = 1'b1;
    endtask

    task automatic test_qpsk();
        bit bits[4] = '{1, 0, 1, 1};
        clear_obs();
        foreach (bits[i]) step(1, bits[i], 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        n_tests++;
        if (obs_w.size() != 2 || obs_w[0] !== 8'h02 || obs_w[1] !== 8'h03 ||
            obs_bps[0] != 2 || obs_bps[1] != 2) begin
            n_fail++;
            $display("FAIL qpsk: got %0d symbols %p expected 02,03 bps 2", obs_w.size(), obs_w);
        end
    endtask

    task automatic test_16qam();
        bit bits[8] = '{1, 1, 0, 1, 0, 0, 1, 0};
        clear_obs();
        foreach (bits[i]) step(1, bits[i], 1, 1, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        n_tests++;
        if (obs_w.size() != 2 || obs_w[0] !== 8'h0D || obs_w[1] !== 8'h02 || obs_bps[0] != 4) begin
            n_fail++;
            $display("FAIL qam16_msb: got %0d symbols %p expected 0d,02", obs_w.size(), obs_w);
        end
        n_tests++;
        if (obs_wb.size() != 2 || obs_wb[0] !== 4'hB || obs_wb[1] !== 4'h4) begin
            n_fail++;
            $display("FAIL qam16_lsb: got %0d symbols %p expected b,4", obs_wb.size(), obs_wb);
        end
    endtask

    task automatic test_clamp();
        bit bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        clear_obs();
        foreach (bits[i]) step(1, bits[i], 3, 1, 0);
        step(0, 0, 3, 1, 0);
        n_tests++;
        if (obs_w.size() != 1 || obs_w[0] !== 8'hA5 || obs_bps[0] != 8) begin
            n_fail++;
            $display("FAIL qam256: got %0d symbols %p expected a5 bps 8", obs_w.size(), obs_w);
        end
        n_tests++;
        if (obs_wb.size() != 2 || obs_wb[0] !== 4'h5 || obs_wb[1] !== 4'hA ||
            obs_bpsb[0] != 4 || obs_bpsb[1] != 4) begin
            n_fail++;
            $display("FAIL clamp4: got %0d symbols %p expected 5,a bps 4", obs_wb.size(), obs_wb);
        end
    endtask

    task automatic test_mode_change();
        clear_obs();
        step(1, 1, 0, 1, 0);
        step(1, 0, 3, 1, 0);
        for (int i = 0; i < 8; i++) step(1, (i < 4), 3, 1, 0);
        step(0, 0, 3, 1, 0);
        n_tests++;
        if (obs_w.size() != 2 || obs_w[0] !== 8'h02 || obs_bps[0] != 2 ||
            obs_w[1] !== 8'hF0 || obs_bps[1] != 8) begin
            n_fail++;
            $display("FAIL mode_change: got %0d symbols %p expected 02/2, f0/8", obs_w.size(), obs_w);
        end
    endtask

    task automatic test_back_to_back();
        step(0, 0, 1, 1, 1);
        clear_obs();
        for (int i = 0; i < 10; i++) step(1, 1'($urandom), 1, 0, 0);
        n_tests++;
        if (acc_cnt != 7) begin
            n_fail++;
            $display("FAIL stall_accept: got %0d bits accepted expected 7", acc_cnt);
        end
        step(1, 1'($urandom), 1, 1, 0);
        n_tests++;
        if (sym_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back: got sym_valid %b expected 1", sym_valid);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
        n_tests++;
        if (obs_w.size() != 2) begin
            n_fail++;
            $display("FAIL back_to_back_count: got %0d symbols expected 2", obs_w.size());
        end
    endtask

    task automatic test_flush();
        bit bits[4] = '{0, 1, 1, 0};
        clear_obs();
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0);
        step(1, 1, 1, 1, 1);
        n_tests++;
        if (bit_idx !== 4'd0 || sym_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: got idx=%0d v=%b expected 0,0", bit_idx, sym_valid);
        end
        foreach (bits[i]) step(1, bits[i], 1, 1, 0);
        step(0, 0, 1, 1, 0);
        n_tests++;
        if (obs_w.size() != 1 || obs_w[0] !== 8'h06) begin
            n_fail++;
            $display("FAIL flush_symbol: got %0d symbols %p expected 06", obs_w.size(), obs_w);
        end
    endtask

    task automatic test_async_reset();
        step(1, 1, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({sym_out, sym_bps, sym_valid, clk_symbol, bit_idx} !== '0 ||
            {sym_out_b, sym_valid_b, clk_symbol_b, bit_idx_b} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got out=%h v=%b clk=%b idx=%0d expected zeros",
                     sym_out, sym_valid, clk_symbol, bit_idx);
        end
        model_reset();
        @(negedge clk_bitstream);
        rst_n = 1'b1;
        clear_obs();
        for (int i = 0; i < 6; i++) step(1, 1'($urandom), 2, 1, 0);
        step(0, 0, 2, 1, 0);
        n_tests++;
        if (obs_bps.size() != 1 || obs_bps[0] != 6) begin
            n_fail++;
            $display("FAIL post_reset_mode: got %0d symbols bps %p expected one of 6",
                     obs_bps.size(), obs_bps);
        end
    endtask

    task automatic test_random();
        int mode = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) mode = int'($urandom_range(0, 3));
            step($urandom_range(0, 9) < 7, 1'($urandom), mode,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_qpsk();
        test_16qam();
        test_clamp();
        test_mode_change();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
